// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared constants for the memory bus arbiter and its byte sequencer:
//   FSM state encodings, data-memory width codes, boolean and zero-word
//   constants, and a helper that maps a width code to a byte count.
//   No ports (package).
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic True_v  = 1'b1;
    localparam logic False_v = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Code 2'b11 is treated as a full word.
    function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
        case (width)
            W_BYTE:  return 3'd1;
            W_HALF:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer
//   Drives the byte-wide RAM port for one transaction at a time. A start
//   pulse in IDLE latches base address, byte count, write data and
//   direction; the FSM then walks RD (N+1 steps, RAM latency of one cycle)
//   or WR (N steps) and spends one cycle in DONE.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global ready; low freezes all state and gates mem_wr
//   start, start_*  transaction request and its latched fields
//   abort           leave RD for IDLE at the next edge (read only)
//   idle, done      FSM is in IDLE / DONE
//   rd_last         this edge captures the final byte of a read
//   rd_word         assembled read word including the byte being captured
//   mem_din/mem_dout/mem_a/mem_wr  RAM pins
module mem_byte_sequencer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [2:0]        start_len,
    input  logic [31:0]       start_wdata,
    input  logic              abort,
    output logic              idle,
    output logic              done,
    output logic              rd_last,
    output logic [31:0]       rd_word,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [2:0]        len;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       acc;
    logic [1:0]        cap_idx;
    logic [31:0]       fill;

    // Byte arriving on mem_din belongs to the address presented one step
    // earlier. Bytes above N stay zero because acc is cleared at start.
    assign cap_idx = 2'(cnt - 3'd1);
    assign fill    = acc | ({24'h000000, mem_din} << {cap_idx, 3'b000});

    assign idle    = (state == ST_IDLE);
    assign done    = (state == ST_DONE);
    assign rd_word = fill;
    assign rd_last = (state == ST_RD) && (cnt == len) && rdy && !abort;

    always_comb begin
        mem_a    = '0;
        mem_dout = 8'h00;
        mem_wr   = False_v;
        case (state)
            ST_RD: begin
                // While frozen, keep the address whose data is due next so
                // mem_din is already correct on the first ready cycle.
                if (!rdy && cnt != 3'd0)
                    mem_a = base + ADDR_W'(cnt - 3'd1);
                else
                    mem_a = base + ADDR_W'(cnt);
            end
            ST_WR: begin
                mem_a    = base + ADDR_W'(cnt);
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                mem_wr   = rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            len   <= 3'd0;
            base  <= '0;
            wdata <= ZeroWord;
            acc   <= ZeroWord;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base  <= start_addr;
                        len   <= start_len;
                        wdata <= start_wdata;
                        acc   <= ZeroWord;
                        cnt   <= 3'd0;
                        state <= start_we ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0)
                            acc <= fill;
                        if (cnt == len)
                            state <= ST_DONE;
                        else
                            cnt <= cnt + 3'd1;
                    end
                end
                ST_WR: begin
                    if (cnt == len - 3'd1)
                        state <= ST_DONE;
                    else
                        cnt <= cnt + 3'd1;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single byte-wide RAM port between instruction fetch (IF)
//   and data memory (DM). Arbitrates in IDLE, hands the winner's request
//   to mem_byte_sequencer, and routes the completed word and a one-cycle
//   ack back to the owner.
//   Build option: define MEM_ARB_RR_EN for round-robin tie breaking
//   (the port not granted last wins a tie); otherwise DM has fixed priority.
// Ports:
//   clk, rst, rdy                       clock, async active-high reset, ready
//   if_req/if_addr/if_clr               IF word read request and flush
//   if_rdata/if_ack                     IF result and completion pulse
//   dm_req/dm_we/dm_width/dm_addr/dm_wdata   DM request fields
//   dm_rdata/dm_ack                     DM result and completion pulse
//   mem_din/mem_dout/mem_a/mem_wr       RAM pins
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_clr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_width,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("mem_bus_arbiter: only RD_LAT = 1 is supported");
    end

    logic        owner_dm;
    logic        grant_dm;
    logic        grant_if;
    logic        start;
    logic        seq_idle;
    logic        seq_done;
    logic        rd_last;
    logic [31:0] rd_word;

`ifdef MEM_ARB_RR_EN
    // Resets to DM so the first tie goes to IF.
    logic last_dm;

    assign grant_dm = dm_req && !(if_req && last_dm);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_dm <= True_v;
        else if (rdy && start)
            last_dm <= grant_dm;
    end
`else
    assign grant_dm = dm_req;
`endif

    assign grant_if = if_req && !grant_dm;
    assign start    = seq_idle && (grant_dm || grant_if);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            owner_dm <= False_v;
        else if (rdy && start)
            owner_dm <= grant_dm;
    end

    mem_byte_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .start       (start),
        .start_we    (grant_dm && dm_we),
        .start_addr  (grant_dm ? dm_addr : if_addr),
        .start_len   (grant_dm ? width_to_bytes(dm_width) : 3'd4),
        .start_wdata (dm_wdata),
        .abort       (if_clr && !owner_dm),
        .idle        (seq_idle),
        .done        (seq_done),
        .rd_last     (rd_last),
        .rd_word     (rd_word),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr)
    );

    // A flush arriving while IF sits in DONE swallows its ack.
    assign if_ack = seq_done && !owner_dm && !if_clr;
    assign dm_ack = seq_done && owner_dm;

    // Result registers change only when a read completes for that port;
    // writes and aborted fetches leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata <= ZeroWord;
            dm_rdata <= ZeroWord;
        end else if (rd_last) begin
            if (owner_dm)
                dm_rdata <= rd_word;
            else
                if_rdata <= rd_word;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between the instruction-fetch requester (IF) and the data-memory requester (DM).
- Arbitrates between the two and sequences multi-byte reads and writes one byte per cycle.
- Returns a whole-word result to the winner with a single-cycle ack.
- Sits between the fetch/MEM stages and the top-level RAM pins (mem_din/mem_dout/mem_a/mem_wr).

Parameters:
- ADDR_W, 32, address width of requester and RAM address buses.
- RD_LAT, 1, RAM read latency in cycles; only value 1 is supported, other values are an elaboration error.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low = freeze.
- if_req  in  1  IF read request; held high until if_ack.
- if_addr  in  32  IF word address (byte address of lowest byte).
- if_clr  in  1  abort the in-flight IF transaction (branch flush).
- if_rdata  out  32  fetched word, little-endian.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  DM request; dm_* fields held stable until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- dm_addr  in  32  DM byte address.
- dm_wdata  in  32  write data; byte i is sent at dm_addr+i.
- dm_rdata  out  32  read data, zero-extended.
- dm_ack  out  1  one-cycle completion pulse.
- mem_din  in  8  RAM read data; valid one cycle after mem_a.
- mem_dout  out  8  RAM write data.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.

Behaviour:
- Reset (async, rst=1): state IDLE; if_rdata=0, dm_rdata=0, if_ack=0, dm_ack=0, mem_dout=0, mem_a=0, mem_wr=0; byte counter 0; last-grant=DM.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Grant DM if dm_req, else IF if if_req (fixed priority; see optional feature).
  - Latch base address, byte count N (1/2/4; IF always 4), write data and owner.
  - Go to RD, or to WR if the owner is DM and dm_we=1.
  - mem_wr=0 and mem_a=0 while in IDLE.
- RD, step i = 0..N:
  - For i<N: mem_a = base+i.
  - For i≥1: at the end of the cycle capture mem_din into byte i-1 of the result.
  - After step N go to DONE. Unfilled upper bytes are 0.
- WR, step i = 0..N-1: mem_wr=1, mem_a=base+i, mem_dout = wdata byte i. After step N-1 go to DONE.
- DONE (one cycle):
  - Owner's ack=1 and its rdata is valid; for writes, rdata is unchanged.
  - Return to IDLE. The acked port is not re-arbitrated until the following IDLE cycle, so a held req starts a new transaction.
- rdata registers hold until overwritten by the next read for the same port.
- Latency from the edge where IDLE samples req to ack high:
  - Reads: N+2 cycles (word = 6).
  - Writes: N+1 cycles (word = 5).
- Address increments wrap modulo 2^32.
- Unaligned accesses are legal; no alignment checks.
- rdy=0:
  - All state, counters and data are frozen; mem_wr forced 0; acks held at their current value.
  - In RD, mem_a presents the address of the byte whose data is due next (base+i-1 when i≥1), so that on the first rdy=1 cycle mem_din is correct for capture.
- if_clr=1 while IF owns RD: at the next edge go to IDLE without if_ack; if_rdata unchanged.
- if_clr during DONE for IF: suppresses if_ack.
- if_clr with IF not owner: no effect.
- DM transactions are never aborted.
- Simultaneous if_req and dm_req in IDLE: DM wins.
- A req change mid-transaction is ignored; fields were latched at grant.

Optional Feature:
- MEM_ARB_RR_EN defined: on a tie, grant the port that was not granted last. last-grant updates on every grant, and its reset value DM means IF wins the first tie.
- MEM_ARB_RR_EN undefined: fixed DM priority; last-grant register removed.

Decomposition:
- Shared defines file holds:
  - state encodings ST_IDLE/ST_RD/ST_WR/ST_DONE;
  - width codes W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10;
  - True_v/False_v and ZeroWord.
- One natural sub-module, mem_byte_sequencer: holds the FSM, counter, address generation, byte capture and the mem_* drives.
- The parent holds arbitration, owner mux and ack/rdata routing.

Test Plan:
- IF word read at 0x100, RAM holds 0x13,0x05,0x00,0x00 → if_ack 6 cycles after req sampled; if_rdata=0x00000513; mem_a sequence 0x100..0x103.
- DM half write of 0xBEEF at 0x2000 → two cycles with mem_wr=1, (0x2000, 0xEF) then (0x2001, 0xBE); dm_ack on the next cycle; RAM bytes 0x2002/0x2003 untouched.
- DM byte read at 0x1F with mem_din=0x80 → dm_rdata=0x00000080 (zero-extended); ack latency 3 cycles.
- if_req and dm_req asserted in the same cycle → DM served first, IF starts in the IDLE cycle after dm_ack. With MEM_ARB_RR_EN, a second simultaneous pair after that → IF first.
- IF read, if_clr pulsed at RD step 2 → no if_ack, FSM in IDLE next cycle; a pending dm_req is granted in that IDLE cycle.
- DM word read with rdy=0 for 3 cycles at RD step 2, then rdst mid-transaction → during the stall mem_wr=0, data correct after resume (0xDEADBEEF); asserting rst afterwards immediately clears all outputs to 0.
